wb_master_adapter: RTL and testbench

Wishbone B4 pipelined master adapter: accepts single transactions from a native valid/ready command port, drives one Wishbone cycle per command, and returns read data and status on a valid/ready response port. It is the initiator-side counterpart of the team's Wishbone slave adapter. It sits between internal masters (DMA engines, debug bridges, CPU shims) and the Wishbone interconnect. A watchdog aborts cycles that never terminate.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_timeout_counter.sv | 55 +++++
 rtl/wb_master_adapter.sv | 190 +++++++++++++++++++
 tb/tb_wb_master_adapter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone definitions used by the team's Wishbone initiators and
// targets.
//   wb_master_state_e  : state encoding of the pipelined master adapter
//   WB_TIMEOUT_DEFAULT : default bus-cycle watchdog limit, in clocks
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } wb_master_state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// ---------------------------------------------------------------------------
// wb_timeout_counter
// Bus-cycle watchdog for Wishbone initiators. The count advances on every
// enabled cycle. "expired" goes high during the enabled cycle in which the
// count reaches LIMIT-1. In that cycle the bus cycle has been open for LIMIT
// clocks. A LIMIT of 0 disables the watchdog.
// Ports:
//   wb_clk_i  : clock, rising edge
//   wb_rst_i  : asynchronous active-high reset
//   clear     : restart the count from zero; this takes priority over enable
//   enable    : count this cycle, because a bus cycle is in progress
//   expired   : the limit has been reached in this cycle
// ---------------------------------------------------------------------------
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int LIMIT = WB_TIMEOUT_DEFAULT
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (LIMIT == 0) begin : g_off
    logic unused_ok;
    assign unused_ok = ^{wb_clk_i, wb_rst_i, clear, enable};
    assign expired   = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
      count_d = count_q;
      if (clear) begin
        count_d = '0;
      end else if (enable) begin
        count_d = count_q + 1'b1;
      end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign expired = enable && !clear && (count_q == CW'(LIMIT - 1));
  end

endmodule

// File: rtl/wb_master_adapter.sv
// ---------------------------------------------------------------------------
// wb_master_adapter
// Wishbone B4 pipelined master adapter. The adapter takes one command at a
// time from a valid/ready command port. For each command it runs one
// Wishbone cycle. It then returns the read data and the status on a
// valid/ready response port. A watchdog aborts any cycle that the slave
// never terminates.
// Ports:
//   wb_clk_i, wb_rst_i         : clock and asynchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake
//   cmd_addr/wdata/we/be       : command payload (byte address, data, dir, enables)
//   rsp_valid/rsp_ready        : response handshake
//   rsp_rdata/err/timeout      : response payload
//   wb_adr_o..wb_stb_o         : Wishbone master outputs, all registered
//   wb_dat_i, wb_ack_i,
//   wb_err_i, wb_stall_i       : Wishbone slave returns
// ---------------------------------------------------------------------------
module wb_master_adapter
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic                    cmd_we,
  input  logic [DATA_WIDTH/8-1:0] cmd_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_stall_i
);

  localparam int SW = DATA_WIDTH / 8;

  wb_master_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
  logic [DATA_WIDTH-1:0]  dat_q, dat_d;
  logic                   we_q, we_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic                   cyc_q, cyc_d;
  logic                   stb_q, stb_d;
  logic                   rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0]  rspRdata_q, rspRdata_d;
  logic                   rspErr_q, rspErr_d;
  logic                   rspTimeout_q, rspTimeout_d;

  logic wdClear, wdEnable, wdExpired;
  logic complete, timedOut;

  assign wdEnable = (state_q == REQ) || (state_q == WAIT);

  wb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clear    (wdClear),
    .enable   (wdEnable),
    .expired  (wdExpired)
  );

  // In REQ, a termination counts only once the strobe is accepted, that is
  // when stall is low. A slave termination in the same cycle as expiry wins
  // over the watchdog. The bus outputs and rsp_valid are registered copies
  // of the decoded next state, so every output except cmd_ready is a flop.
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    sel_d        = sel_q;
    rspRdata_d   = rspRdata_q;
    rspErr_d     = rspErr_q;
    rspTimeout_d = rspTimeout_q;
    wdClear      = 1'b0;
    complete     = 1'b0;
    timedOut     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_addr;
          dat_d   = cmd_wdata;
          we_d    = cmd_we;
          sel_d   = cmd_be;
          wdClear = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!wb_stall_i && (wb_ack_i || wb_err_i)) begin
          complete = 1'b1;
        end else if (wdExpired) begin
          timedOut = 1'b1;
        end else if (!wb_stall_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wb_ack_i || wb_err_i) begin
          complete = 1'b1;
        end else if (wdExpired) begin
          timedOut = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // On a termination, err takes priority over ack. Read data is returned
    // only for a clean ack of a read.
    if (complete) begin
      state_d      = RESP;
      rspErr_d     = wb_err_i;
      rspTimeout_d = 1'b0;
      rspRdata_d   = (wb_ack_i && !wb_err_i && !we_q) ? wb_dat_i : '0;
    end else if (timedOut) begin
      state_d      = RESP;
      rspErr_d     = 1'b1;
      rspTimeout_d = 1'b1;
      rspRdata_d   = '0;
    end

    cyc_d      = (state_d == REQ) || (state_d == WAIT);
    stb_d      = (state_d == REQ);
    rspValid_d = (state_d == RESP);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= '0;
      rspErr_q     <= 1'b0;
      rspTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      rspValid_q   <= rspValid_d;
      rspRdata_q   <= rspRdata_d;
      rspErr_q     <= rspErr_d;
      rspTimeout_q <= rspTimeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rspValid_q;
  assign rsp_rdata   = rspRdata_q;
  assign rsp_err     = rspErr_q;
  assign rsp_timeout = rspTimeout_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;

endmodule

// File: tb/tb_wb_master_adapter.sv
// ---------------------------------------------------------------------------
// tb_wb_master_adapter
// Directed and randomized bench for wb_master_adapter, with the watchdog
// limit set to 8. For each transaction, the expected latency and response
// are computed from the slave's scripted behaviour: its stall count, its
// acknowledge delay, and whether it signals an error or stays silent.
// ---------------------------------------------------------------------------
module tb_wb_master_adapter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 8;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_be;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_ack_i, wb_err_i, wb_stall_i;

  int nVectors = 0;
  int nMiscompares = 0;

  wb_master_adapter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_we(cmd_we), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nVectors++;
    assert (observed === expected)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic quietSlave();
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    wb_stall_i = 1'b0;
    wb_dat_i   = $urandom;
  endtask

  // Runs one command through the adapter while acting as the slave.
  // Cycle k=1 is the first cycle after the command handshake.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int stallCycles, input int ackDelay,
                               input logic errFlag, input logic errWithAck,
                               input logic silent, input int rspHold,
                               input logic [31:0] rdData);
    int ackAt, expCyc, expStb, expRsp, cycHigh, stbHigh, rspAt, held;
    logic expTo, expErr, done;
    logic [31:0] expRdata;

    // Reference: the slave terminates in cycle ackAt. The watchdog fires
    // instead when that cycle lies beyond the T-cycle window.
    ackAt    = stallCycles + 1 + ackDelay;
    expTo    = silent || (ackAt > T);
    expErr   = expTo || errFlag;
    expRdata = (!we && !expErr) ? rdData : 32'h0;
    expCyc   = expTo ? T : ackAt;
    expStb   = (stallCycles + 1 < expCyc) ? stallCycles + 1 : expCyc;
    expRsp   = expCyc + 1;

    @(negedge clk);
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    cycHigh = 0; stbHigh = 0; rspAt = 0; held = 0; done = 1'b0;

    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = $urandom; cmd_wdata = $urandom; cmd_we = $urandom; cmd_be = $urandom;
      if (k == 1) begin
        checkOutput("cyc_first", wb_cyc_o, 1);
        checkOutput("stb_first", wb_stb_o, 1);
        checkOutput("adr_o", wb_adr_o, addr);
        checkOutput("dat_o", wb_dat_o, wdata);
        checkOutput("sel_o", wb_sel_o, be);
        checkOutput("we_o", wb_we_o, we);
      end
      if (wb_cyc_o) cycHigh++;
      if (wb_stb_o) stbHigh++;
      if (rsp_valid) begin
        if (rspAt == 0) rspAt = k;
        checkOutput("rsp_rdata", rsp_rdata, expRdata);
        checkOutput("rsp_err", rsp_err, expErr);
        checkOutput("rsp_timeout", rsp_timeout, expTo);
        checkOutput("cmd_ready_resp", cmd_ready, 0);
        checkOutput("cyc_resp", wb_cyc_o, 0);
        if (held >= rspHold) begin
          rsp_ready = 1'b1;
          done = 1'b1;
        end else begin
          held++;
          rsp_ready = 1'b0;
        end
      end
      wb_stall_i = (k <= stallCycles);
      wb_ack_i   = (!silent && k == ackAt && (!errFlag || errWithAck)) ||
                   (silent && k == T + 1);
      wb_err_i   = !silent && errFlag && k == ackAt;
      wb_dat_i   = (wb_ack_i) ? rdData : $urandom;
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    quietSlave();
    checkOutput("rsp_seen", (rspAt != 0), 1);
    checkOutput("rsp_cycle", rspAt, expRsp);
    checkOutput("cyc_high_cycles", cycHigh, expCyc);
    checkOutput("stb_high_cycles", stbHigh, expStb);
    checkOutput("rsp_valid_after", rsp_valid, 0);
    checkOutput("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    logic errFlag;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    rsp_ready = 1'b0;
    quietSlave();

    #1;
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_cyc", wb_cyc_o, 0);
    checkOutput("reset_stb", wb_stb_o, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_adr", wb_adr_o, 0);
    checkOutput("reset_sel_we", {wb_sel_o, wb_we_o}, 0);
    checkOutput("reset_rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single write with an ack one cycle after the strobe.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    // Read with three stalled cycles.
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 3, 1, 1'b0, 1'b0, 1'b0, 0, 32'h12345678);
    // Read that terminates with err and ack together.
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h3, 0, 1, 1'b1, 1'b1, 1'b0, 0, 32'hCAFEF00D);
    // Silent slave followed by a late ack.
    applyStimulus(1'b0, 32'h40, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 1'b1, 0, 32'h55AA55AA);
    // Response held back for 5 cycles.
    applyStimulus(1'b0, 32'h50, 32'h0, 4'hC, 1, 0, 1'b0, 1'b0, 1'b0, 5, 32'hA5A5F00F);
    // Ack in the last cycle of the watchdog window, then one cycle too late.
    applyStimulus(1'b0, 32'h60, 32'h0, 4'hF, 3, 4, 1'b0, 1'b0, 1'b0, 0, 32'h01020304);
    applyStimulus(1'b1, 32'h64, 32'h99, 4'h1, 3, 5, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    // Ack in the same cycle as the accepted strobe.
    applyStimulus(1'b0, 32'h70, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 1'b0, 0, 32'hFEEDFACE);

    // Reset while the adapter waits for the slave.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h80; cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("wait_cyc", wb_cyc_o, 1);
    checkOutput("wait_stb", wb_stb_o, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_cyc", wb_cyc_o, 0);
    checkOutput("rst_mid_stb", wb_stb_o, 0);
    checkOutput("rst_mid_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wb_ack_i = (k == 1);
      wb_dat_i = 32'hBAD0BAD0;
      @(negedge clk);
      checkOutput("rst_no_rsp", rsp_valid, 0);
      checkOutput("rst_no_cyc", wb_cyc_o, 0);
    end
    quietSlave();
    applyStimulus(1'b0, 32'h84, 32'h0, 4'hF, 1, 1, 1'b0, 1'b0, 1'b0, 0, 32'h13579BDF);

    // Randomized transactions.
    for (int i = 0; i < 24; i++) begin
      errFlag = ($urandom_range(4) == 0);
      applyStimulus($urandom, $urandom, $urandom, $urandom,
                    $urandom_range(5), $urandom_range(5), errFlag, $urandom,
                    ($urandom_range(7) == 0), $urandom_range(3), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
